// File: rtl/fp_to_int64_iter_if.sv
// fp_to_int64_iter_if
//   Request/response bundle for the iterative float-to-64-bit-integer converter.
//   Request side : in_valid/in_ready handshake, operand_in, input_type,
//                  out_signed, rounding_mode.
//   Response side: out_valid/out_ready handshake, result, flag_invalid,
//                  flag_inexact.
//   master = issuing unit (FPU issue stage / testbench), slave = converter.
interface fp_to_int64_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] operand_in;
  logic [1:0]  input_type;
  logic        out_signed;
  logic [2:0]  rounding_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flag_invalid;
  logic        flag_inexact;

  modport master (
    output in_valid, operand_in, input_type, out_signed, rounding_mode, out_ready,
    input  in_ready, out_valid, result, flag_invalid, flag_inexact
  );

  modport slave (
    input  in_valid, operand_in, input_type, out_signed, rounding_mode, out_ready,
    output in_ready, out_valid, result, flag_invalid, flag_inexact
  );
endinterface

// File: rtl/fp_to_int64_if.sv
// fp_to_int64_if
//   The converter's request/response interface is defined in fp_to_int64_iter_if.sv.

// File: rtl/fp_to_int64_iter.sv
// fp_to_int64_iter
//   Multi-cycle FP32/FP64 -> INT64/UINT64 converter supporting RNE, RTZ, RDN,
//   RUP and RMM. Right-alignment of the significand is done iteratively, at
//   most SHIFT_STEP bits per ALIGN cycle, so only a small shifter is needed.
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low reset (aborts any operation in flight)
//     bus    - fp_to_int64_iter_if.slave: request handshake + operand/controls,
//              response handshake + result and invalid/inexact flags
//   Parameter:
//     SHIFT_STEP - maximum right-shift per ALIGN cycle (1..64)
module fp_to_int64_iter #(
  parameter int SHIFT_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_to_int64_iter_if.slave   bus
);

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [6:0]  STEP     = 7'(SHIFT_STEP);
  // Any magnitude >= 2^64 saturates in every range check; used for NaN/Inf/overflow.
  localparam logic [64:0] MAG_HUGE = {1'b1, 64'd0};

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  typedef struct packed {
    logic        invalid;
    logic        inexact;
    logic [63:0] value;
  } conv_res_t;

  // Round-up decision for values already aligned to the integer point.
  function automatic logic round_incr(input logic [2:0] rm, input logic neg,
                                      input logic lsb, input logic g, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = neg & (g | s);
      RM_RUP:  inc = ~neg & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (lsb | s);
    endcase
    return inc;
  endfunction

  // Round-up decision for |x| < 1 (nonzero): only unb == -1 can reach or exceed one half.
  function automatic logic tiny_incr(input logic [2:0] rm, input logic neg,
                                     input logic half_or_more, input logic above_half);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = neg;
      RM_RUP:  inc = ~neg;
      RM_RMM:  inc = half_or_more;
      default: inc = above_half;
    endcase
    return inc;
  endfunction

  // Applies sign and destination range; saturation sets invalid and clears inexact.
  function automatic conv_res_t range_check(input logic [64:0] mag, input logic neg,
                                            input logic to_signed, input logic inexact);
    conv_res_t r;
    logic signed [63:0] neg_val;
    r.invalid = 1'b0;
    r.inexact = inexact;
    r.value   = 64'd0;
    neg_val   = -$signed(mag[63:0]);
    if (to_signed) begin
      if (!neg) begin
        if (mag > 65'h0_7FFF_FFFF_FFFF_FFFF) begin
          r.invalid = 1'b1;
          r.inexact = 1'b0;
          r.value   = 64'h7FFF_FFFF_FFFF_FFFF;
        end else begin
          r.value = mag[63:0];
        end
      end else begin
        if (mag > 65'h0_8000_0000_0000_0000) begin
          r.invalid = 1'b1;
          r.inexact = 1'b0;
          r.value   = 64'h8000_0000_0000_0000;
        end else begin
          r.value = neg_val;
        end
      end
    end else begin
      if (neg) begin
        // -0 after rounding is a legal unsigned zero; anything else is out of range.
        if (mag != 65'd0) begin
          r.invalid = 1'b1;
          r.inexact = 1'b0;
        end
      end else if (mag[64]) begin
        r.invalid = 1'b1;
        r.inexact = 1'b0;
        r.value   = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        r.value = mag[63:0];
      end
    end
    return r;
  endfunction

  state_t state_q, state_d;

  // Decode of the operand presented on the bus (used only at accept).
  logic               is_fp64;
  logic               sign_in;
  logic [10:0]        exp_raw;
  logic [51:0]        frac_in;
  logic               exp_all1;
  logic signed [12:0] bias;
  logic signed [12:0] unb;
  logic               is_nan, is_inf, is_zero;
  logic               is_special, no_shift;
  logic [2:0]         rm_in;
  logic [52:0]        m_in;
  logic [3:0]         lsh_in;
  logic [6:0]         rs_in;
  logic [64:0]        spec_mag;
  logic               spec_neg, spec_inx;
  conv_res_t          spec_res;

  always_comb begin
    is_fp64 = (bus.input_type != 2'b00);
    if (is_fp64) begin
      sign_in  = bus.operand_in[63];
      exp_raw  = bus.operand_in[62:52];
      frac_in  = bus.operand_in[51:0];
      exp_all1 = &bus.operand_in[62:52];
      bias     = 13'sd1023;
    end else begin
      sign_in  = bus.operand_in[31];
      exp_raw  = {3'b000, bus.operand_in[30:23]};
      frac_in  = {bus.operand_in[22:0], 29'd0};
      exp_all1 = &bus.operand_in[30:23];
      bias     = 13'sd127;
    end
    unb     = $signed({2'b00, exp_raw}) - bias;
    is_nan  = exp_all1 & (|frac_in);
    is_inf  = exp_all1 & ~(|frac_in);
    is_zero = (exp_raw == 11'd0) & ~(|frac_in);
    rm_in   = (bus.rounding_mode > RM_RMM) ? RM_RNE : bus.rounding_mode;

    is_special = is_nan | is_inf | is_zero | (unb >= 13'sd64) | (unb < 13'sd0);
    no_shift   = (unb >= 13'sd52);
    m_in       = {1'b1, frac_in};
    lsh_in     = 4'(unb - 13'sd52);
    rs_in      = 7'(13'sd52 - unb);

    spec_mag = 65'd0;
    spec_neg = sign_in;
    spec_inx = 1'b0;
    if (is_nan) begin
      spec_mag = MAG_HUGE;
      spec_neg = 1'b0;
    end else if (is_inf || (unb >= 13'sd64)) begin
      spec_mag = MAG_HUGE;
    end else if (is_zero) begin
      spec_mag = 65'd0;
    end else begin
      spec_mag = {64'd0, tiny_incr(rm_in, sign_in, unb == -13'sd1,
                                   (unb == -13'sd1) && (frac_in != 52'd0))};
      spec_inx = 1'b1;
    end
    spec_res = range_check(spec_mag, spec_neg, bus.out_signed, spec_inx);
  end

  // Operation context and alignment datapath (data only, no reset).
  logic        sign_p0, signed_p0;
  logic [2:0]  mode_p0;
  logic [63:0] acc_p1;
  logic        g_p1, s_p1;
  logic [6:0]  rs_p1;

  logic [6:0]  k;
  logic [63:0] low_mask, rest_mask;
  logic [63:0] acc_nxt;
  logic        g_nxt, s_nxt;
  logic [6:0]  rs_nxt;

  always_comb begin
    k         = (rs_p1 < STEP) ? rs_p1 : STEP;
    low_mask  = (64'd1 << k) - 64'd1;
    rest_mask = (64'd1 << (k - 7'd1)) - 64'd1;
    // Guard is the top bit of the shifted-out field; everything below it and
    // the previous guard fold into sticky.
    g_nxt     = |(acc_p1 & low_mask & ~rest_mask);
    s_nxt     = s_p1 | g_p1 | (|(acc_p1 & rest_mask));
    acc_nxt   = acc_p1 >> k;
    rs_nxt    = rs_p1 - k;
  end

  logic        incr;
  logic [64:0] round_mag;
  conv_res_t   round_res;

  always_comb begin
    incr      = round_incr(mode_p0, sign_p0, acc_p1[0], g_p1, s_p1);
    round_mag = {1'b0, acc_p1} + {64'd0, incr};
    round_res = range_check(round_mag, sign_p0, signed_p0, g_p1 | s_p1);
  end

  // ---- stage p0/p1: capture at accept, iterate during ALIGN ----
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid) begin
      sign_p0   <= sign_in;
      signed_p0 <= bus.out_signed;
      mode_p0   <= rm_in;
      g_p1      <= 1'b0;
      s_p1      <= 1'b0;
      if (no_shift) begin
        acc_p1 <= {11'd0, m_in} << lsh_in;
        rs_p1  <= 7'd0;
      end else begin
        acc_p1 <= {11'd0, m_in};
        rs_p1  <= rs_in;
      end
    end else if (state_q == ALIGN) begin
      acc_p1 <= acc_nxt;
      g_p1   <= g_nxt;
      s_p1   <= s_nxt;
      rs_p1  <= rs_nxt;
    end
  end

  // ---- stage p2: result registers, written only on entry to DONE ----
  logic [63:0] result_p2;
  logic        invalid_p2, inexact_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p2  <= 64'd0;
      invalid_p2 <= 1'b0;
      inexact_p2 <= 1'b0;
    end else if (state_q == IDLE && bus.in_valid && is_special) begin
      result_p2  <= spec_res.value;
      invalid_p2 <= spec_res.invalid;
      inexact_p2 <= spec_res.inexact;
    end else if (state_q == ROUND) begin
      result_p2  <= round_res.value;
      invalid_p2 <= round_res.invalid;
      inexact_p2 <= round_res.inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic vld_p2, rdy_p0;

  always_comb begin
    state_d = state_q;
    rdy_p0  = 1'b0;
    vld_p2  = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_p0 = 1'b1;
        if (bus.in_valid) begin
          if (is_special)    state_d = DONE;
          else if (no_shift) state_d = ROUND;
          else               state_d = ALIGN;
        end
      end
      ALIGN: if (rs_nxt == 7'd0) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE: begin
        vld_p2 = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = rdy_p0;
  assign bus.out_valid    = vld_p2;
  assign bus.result       = result_p2;
  assign bus.flag_invalid = invalid_p2;
  assign bus.flag_inexact = inexact_p2;

endmodule
